// File: rtl/uart_pkg.sv
// Shared UART receive definitions: parity encodings, rx state codes
// and the parity check helper.
package uart_pkg;

   localparam logic [1:0] PARITY_NONE  = 2'b00;
   localparam logic [1:0] PARITY_ODD   = 2'b01;
   localparam logic [1:0] PARITY_EVEN  = 2'b10;
   localparam logic [1:0] PARITY_NONE2 = 2'b11;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_PARITY    = 3'd3;
   localparam logic [2:0] ST_STOP      = 3'd4;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

   // dataXor is the reduction XOR of the received data bits
   function automatic logic parity_error(
      input logic [1:0] ptype,
      input logic       dataXor,
      input logic       pBit
   );
      logic err;
      err = 1'b0;
      unique case (1'b1)
         (ptype == PARITY_ODD):  err = ~(dataXor ^ pBit);
         (ptype == PARITY_EVEN): err = dataXor ^ pBit;
         default:                err = 1'b0;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous serial line.
// Resets to 1 so a reset never looks like a start bit.
module uart_rx_sync
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Din,
   output logic Dout
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         chain <= '1;
      end else begin
         chain[0] <= Din;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign Dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deframer: oversampled start detect, LSB-first data,
// optional parity, one or two stop bits, per-frame error flags.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  BaudTick,
   input  logic                  RxIn,
   input  logic [1:0]            ParityType,
   input  logic                  StopBits,
   output logic [DATA_WIDTH-1:0] DataOut,
   output logic                  DataValid,
   output logic                  ParityError,
   output logic                  FrameError,
   output logic                  Busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH + 1);

   localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

   logic                  rxSync;
   logic [2:0]            state;
   logic [TW-1:0]         tickCnt;
   logic [BW-1:0]         bitCnt;
   logic [DATA_WIDTH-1:0] shiftReg;
   logic [1:0]            parLat;
   logic                  stopLat;
   logic                  stopIdx;
   logic                  parAcc;
   logic                  frmAcc;
   logic                  pending;
   logic                  usePar;
   logic                  stopBad;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) uSync (
      .Clock (Clock),
      .Reset (Reset),
      .Din   (RxIn),
      .Dout  (rxSync)
   );

   assign usePar  = (parLat == PARITY_ODD) || (parLat == PARITY_EVEN);
   assign stopBad = frmAcc | ~rxSync;
   assign Busy    = (state != ST_IDLE);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= ST_IDLE;
         tickCnt     <= '0;
         bitCnt      <= '0;
         shiftReg    <= '0;
         parLat      <= PARITY_NONE;
         stopLat     <= 1'b0;
         stopIdx     <= 1'b0;
         parAcc      <= 1'b0;
         frmAcc      <= 1'b0;
         pending     <= 1'b0;
         DataOut     <= '0;
         DataValid   <= 1'b0;
         ParityError <= 1'b0;
         FrameError  <= 1'b0;
      end else begin
         DataValid <= 1'b0;
         // Deliver one Clock after the final stop sample, tick or not
         if (pending) begin
            pending     <= 1'b0;
            DataValid   <= 1'b1;
            DataOut     <= shiftReg;
            ParityError <= parAcc;
            FrameError  <= frmAcc;
         end
         if (BaudTick) begin
            unique case (1'b1)
               (state == ST_IDLE): begin
                  if (!rxSync) begin
                     state   <= ST_START;
                     tickCnt <= '0;
                     parLat  <= ParityType;
                     stopLat <= StopBits;
                     parAcc  <= 1'b0;
                     frmAcc  <= 1'b0;
                  end
               end
               (state == ST_START): begin
                  if (tickCnt == MID_TICK) begin
                     tickCnt <= '0;
                     bitCnt  <= '0;
                     state   <= rxSync ? ST_IDLE : ST_DATA;
                  end else begin
                     tickCnt <= tickCnt + 1'b1;
                  end
               end
               (state == ST_DATA): begin
                  if (tickCnt == LAST_TICK) begin
                     tickCnt  <= '0;
                     shiftReg <= {rxSync, shiftReg[DATA_WIDTH-1:1]};
                     bitCnt   <= bitCnt + 1'b1;
                     if (bitCnt == LAST_BIT) begin
                        stopIdx <= 1'b0;
                        state   <= usePar ? ST_PARITY : ST_STOP;
                     end
                  end else begin
                     tickCnt <= tickCnt + 1'b1;
                  end
               end
               (state == ST_PARITY): begin
                  if (tickCnt == LAST_TICK) begin
                     tickCnt <= '0;
                     parAcc  <= parity_error(parLat, ^shiftReg, rxSync);
                     stopIdx <= 1'b0;
                     state   <= ST_STOP;
                  end else begin
                     tickCnt <= tickCnt + 1'b1;
                  end
               end
               (state == ST_STOP): begin
                  if (tickCnt == LAST_TICK) begin
                     tickCnt <= '0;
                     frmAcc  <= stopBad;
                     if (stopIdx == stopLat) begin
                        pending <= 1'b1;
                        state   <= stopBad ? ST_WAIT_IDLE : ST_IDLE;
                     end else begin
                        stopIdx <= 1'b1;
                     end
                  end else begin
                     tickCnt <= tickCnt + 1'b1;
                  end
               end
               (state == ST_WAIT_IDLE): begin
                  if (rxSync) begin
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: expected frames queued at send
// time, delivered frames captured by a monitor and compared per test.
module tb_uart_rx_frame;
   import uart_pkg::*;

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       fe;
      int         cyc;
   } rec_t;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       BaudTick = 1'b1;
   logic       RxIn = 1'b1;
   logic [1:0] ParityType = PARITY_NONE;
   logic       StopBits = 1'b0;
   logic [7:0] DataOut;
   logic       DataValid;
   logic       ParityError;
   logic       FrameError;
   logic       Busy;

   rec_t expQ[$];
   rec_t obsQ[$];
   int   nRun = 0;
   int   nFail = 0;
   int   cyc = 0;
   int   validCnt = 0;
   int   tickDiv = 1;
   int   divCnt = 0;

   uart_rx_frame #(
      .DATA_WIDTH(8),
      .OVERSAMPLE(16),
      .SYNC_STAGES(2)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .BaudTick    (BaudTick),
      .RxIn        (RxIn),
      .ParityType  (ParityType),
      .StopBits    (StopBits),
      .DataOut     (DataOut),
      .DataValid   (DataValid),
      .ParityError (ParityError),
      .FrameError  (FrameError),
      .Busy        (Busy)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc++;

   always @(negedge Clock) begin
      divCnt = (divCnt + 1) % tickDiv;
      BaudTick = (divCnt == 0);
   end

   always @(negedge Clock) begin
      if (DataValid === 1'b1) begin
         obsQ.push_back('{DataOut, ParityError, FrameError, cyc});
         validCnt++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic hold_bit(input logic v);
      RxIn = v;
      idle(16 * tickDiv);
   endtask

   task automatic send_frame(
      input logic [7:0] d,
      input logic [1:0] pt,
      input logic       p,
      input logic       sb2,
      input logic       s1,
      input logic       s2
   );
      logic pe;
      logic fe;
      pe = 1'b0;
      if (pt == PARITY_ODD)  pe = ~(^d ^ p);
      if (pt == PARITY_EVEN) pe = ^d ^ p;
      fe = ~s1 | (sb2 & ~s2);
      expQ.push_back('{d, pe, fe, 0});
      ParityType = pt;
      StopBits = sb2;
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(d[i]);
      if (pt == PARITY_ODD || pt == PARITY_EVEN) hold_bit(p);
      hold_bit(s1);
      if (sb2) hold_bit(s2);
      RxIn = 1'b1;
      idle(32 * tickDiv);
   endtask

   task automatic collect(output rec_t e, output rec_t o, output bit ok);
      ok = (expQ.size() > 0) && (obsQ.size() > 0);
      e = '{8'h00, 1'b0, 1'b0, 0};
      o = '{8'h00, 1'b0, 1'b0, 0};
      if (ok) begin
         e = expQ.pop_front();
         o = obsQ.pop_front();
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      idle(4);
      nRun++;
      if (DataOut !== 8'h00) begin
         nFail++; $display("FAIL rst_data got %h want 00", DataOut);
      end
      nRun++;
      if (DataValid !== 1'b0) begin
         nFail++; $display("FAIL rst_valid got %b want 0", DataValid);
      end
      nRun++;
      if (ParityError !== 1'b0) begin
         nFail++; $display("FAIL rst_pe got %b want 0", ParityError);
      end
      nRun++;
      if (FrameError !== 1'b0) begin
         nFail++; $display("FAIL rst_fe got %b want 0", FrameError);
      end
      nRun++;
      if (Busy !== 1'b0) begin
         nFail++; $display("FAIL rst_busy got %b want 0", Busy);
      end
      Reset = 1'b0;
      idle(4);
   endtask

   task automatic test_odd_parity(input string tag);
      int   vc0;
      rec_t e;
      rec_t o;
      bit   ok;
      vc0 = validCnt;
      send_frame(8'hA5, PARITY_ODD, 1'b1, 1'b0, 1'b1, 1'b1);
      nRun++;
      if (validCnt - vc0 !== 1) begin
         nFail++; $display("FAIL %s_pulses got %0d want 1", tag, validCnt - vc0);
      end
      collect(e, o, ok);
      nRun++;
      if (!ok) begin
         nFail++; $display("FAIL %s_present got none want frame", tag);
      end
      nRun++;
      if (o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
         nFail++;
         $display("FAIL %s_frame got %h/%b/%b want %h/%b/%b",
                  tag, o.data, o.pe, o.fe, e.data, e.pe, e.fe);
      end
   endtask

   task automatic test_parity_error();
      rec_t e;
      rec_t o;
      bit   ok;
      send_frame(8'hA5, PARITY_ODD, 1'b0, 1'b0, 1'b1, 1'b1);
      collect(e, o, ok);
      nRun++;
      if (!ok || o.data !== e.data || o.pe !== 1'b1 || o.pe !== e.pe) begin
         nFail++;
         $display("FAIL perr_bad got %h/%b want %h/1", o.data, o.pe, e.data);
      end
      send_frame(8'h3C, PARITY_ODD, 1'b1, 1'b0, 1'b1, 1'b1);
      collect(e, o, ok);
      nRun++;
      if (!ok || o.data !== e.data || o.pe !== 1'b0 || o.fe !== 1'b0) begin
         nFail++;
         $display("FAIL perr_clear got %h/%b/%b want 3c/0/0", o.data, o.pe, o.fe);
      end
   endtask

   task automatic test_no_parity();
      rec_t e;
      rec_t o;
      bit   ok;
      int   c0;
      int   lat;
      c0 = cyc;
      send_frame(8'h3C, PARITY_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
      collect(e, o, ok);
      lat = o.cyc - c0;
      nRun++;
      if (!ok || o.data !== e.data || o.pe !== 1'b0 || o.fe !== 1'b0) begin
         nFail++;
         $display("FAIL nopar_frame got %h/%b/%b want 3c/0/0", o.data, o.pe, o.fe);
      end
      nRun++;
      if (lat < 150 || lat > 160) begin
         nFail++; $display("FAIL nopar_latency got %0d want 150..160", lat);
      end
      send_frame(8'h07, PARITY_EVEN, 1'b1, 1'b0, 1'b1, 1'b1);
      collect(e, o, ok);
      nRun++;
      if (!ok || o.data !== e.data || o.pe !== 1'b0 || o.pe !== e.pe) begin
         nFail++;
         $display("FAIL even_frame got %h/%b want 07/0", o.data, o.pe);
      end
   endtask

   task automatic test_glitch();
      int vc0;
      int k;
      vc0 = validCnt;
      ParityType = PARITY_NONE;
      RxIn = 1'b0;
      idle(4);
      RxIn = 1'b1;
      nRun++;
      if (Busy !== 1'b1) begin
         nFail++; $display("FAIL glitch_busy_rise got %b want 1", Busy);
      end
      k = 0;
      while (Busy !== 1'b0 && k < 8) begin
         idle(1);
         k++;
      end
      nRun++;
      if (Busy !== 1'b0) begin
         nFail++; $display("FAIL glitch_busy_fall got %b after %0d want 0", Busy, k);
      end
      idle(64);
      nRun++;
      if (validCnt !== vc0) begin
         nFail++; $display("FAIL glitch_valid got %0d want 0", validCnt - vc0);
      end
   endtask

   task automatic test_break();
      int   vc0;
      rec_t e;
      rec_t o;
      bit   ok;
      vc0 = validCnt;
      ParityType = PARITY_NONE;
      StopBits = 1'b0;
      expQ.push_back('{8'h00, 1'b0, 1'b1, 0});
      RxIn = 1'b0;
      idle(20 * 16);
      nRun++;
      if (validCnt - vc0 !== 1) begin
         nFail++; $display("FAIL break_pulses got %0d want 1", validCnt - vc0);
      end
      collect(e, o, ok);
      nRun++;
      if (!ok || o.data !== e.data || o.fe !== e.fe || o.pe !== e.pe) begin
         nFail++;
         $display("FAIL break_frame got %h/%b/%b want 00/0/1", o.data, o.pe, o.fe);
      end
      nRun++;
      if (Busy !== 1'b1) begin
         nFail++; $display("FAIL break_hold got busy %b want 1", Busy);
      end
      RxIn = 1'b1;
      idle(32);
      nRun++;
      if (Busy !== 1'b0) begin
         nFail++; $display("FAIL break_release got busy %b want 0", Busy);
      end
      send_frame(8'h81, PARITY_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
      collect(e, o, ok);
      nRun++;
      if (!ok || o.data !== e.data || o.fe !== 1'b0 || o.pe !== 1'b0) begin
         nFail++;
         $display("FAIL break_next got %h/%b/%b want 81/0/0", o.data, o.pe, o.fe);
      end
   endtask

   task automatic test_two_stop_and_reset();
      int   vc0;
      rec_t e;
      rec_t o;
      bit   ok;
      send_frame(8'h96, PARITY_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
      collect(e, o, ok);
      nRun++;
      if (!ok || o.data !== e.data || o.fe !== 1'b1 || o.fe !== e.fe) begin
         nFail++;
         $display("FAIL stop2_frame got %h/%b want 96/1", o.data, o.fe);
      end
      vc0 = validCnt;
      ParityType = PARITY_NONE;
      StopBits = 1'b0;
      RxIn = 1'b0;
      idle(16 * 3);
      nRun++;
      if (Busy !== 1'b1 || FrameError !== 1'b1) begin
         nFail++;
         $display("FAIL midrst_pre got busy %b fe %b want 1/1", Busy, FrameError);
      end
      Reset = 1'b1;
      RxIn = 1'b1;
      idle(1);
      Reset = 1'b0;
      nRun++;
      if (Busy !== 1'b0 || FrameError !== 1'b0 || ParityError !== 1'b0 ||
          DataValid !== 1'b0 || DataOut !== 8'h00) begin
         nFail++;
         $display("FAIL midrst_clear got %b/%b/%b/%b/%h want 0/0/0/0/00",
                  Busy, FrameError, ParityError, DataValid, DataOut);
      end
      idle(48);
      nRun++;
      if (validCnt !== vc0) begin
         nFail++; $display("FAIL midrst_valid got %0d want 0", validCnt - vc0);
      end
      send_frame(8'h5A, PARITY_ODD, 1'b1, 1'b0, 1'b1, 1'b1);
      collect(e, o, ok);
      nRun++;
      if (!ok || o.data !== e.data || o.pe !== 1'b0 || o.fe !== 1'b0) begin
         nFail++;
         $display("FAIL midrst_next got %h/%b/%b want 5a/0/0", o.data, o.pe, o.fe);
      end
   endtask

   task automatic test_slow_tick();
      tickDiv = 3;
      idle(6);
      test_odd_parity("slow");
      tickDiv = 1;
      idle(6);
   endtask

   initial begin
      test_reset();
      test_odd_parity("odd");
      test_parity_error();
      test_no_parity();
      test_glitch();
      test_break();
      test_two_stop_and_reset();
      test_slow_tick();
      nRun++;
      if (obsQ.size() !== 0) begin
         nFail++; $display("FAIL leftover got %0d frames want 0", obsQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", nRun, nFail);
      $finish;
   end

endmodule
